// File: rtl/bic_pkg.sv
// Shared definitions for the bi-directional chat serial link.
// The transmit side uses these too.
package bic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rxState_t;

    localparam int FRAME_BITS         = 10;
    localparam int DEFAULT_DATA_BITS  = 8;
    localparam int DEFAULT_OVERSAMPLE = 16;
    localparam int DEFAULT_MID_SAMPLE = 7;

endpackage

// File: rtl/bic_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both flops reset to 1, which is the idle level of a serial line.
module bic_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;
    logic stable;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta   <= 1'b1;
            stable <= 1'b1;
        end else begin
            meta   <= d;
            stable <= meta;
        end
    end

    assign q = stable;

endmodule

// File: rtl/bic_receive_ctrl.sv
// Receive controller for the chat serial link: start detection, mid-bit sampling
// on the oversample tick, and 8N1 frame assembly with a framing-error flag.
module bic_receive_ctrl
    import bic_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int MID_SAMPLE = DEFAULT_MID_SAMPLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 recvEn,
    input  logic                 sampleTick,
    input  logic                 serIn,
    output logic [DATA_BITS-1:0] rxData,
    output logic                 charReceived,
    output logic                 frameErr,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS) + 1;
    localparam logic [CW-1:0] MID_CNT  = CW'(MID_SAMPLE);
    localparam logic [CW-1:0] LAST_CNT = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic serS;

    rxState_t             stateReg,     stateNext;
    logic [CW-1:0]        sampleCntReg, sampleCntNext;
    logic [BW-1:0]        bitIDCountReg, bitIDCountNext;
    logic [DATA_BITS-1:0] shiftReg,     shiftNext;
    logic [DATA_BITS-1:0] rxDataReg,    rxDataNext;
    logic                 charRecReg,   charRecNext;
    logic                 frameErrReg,  frameErrNext;

    bic_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (serIn),
        .q   (serS)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg      <= IDLE;
            sampleCntReg  <= '0;
            bitIDCountReg <= '0;
            shiftReg      <= '0;
            rxDataReg     <= '0;
            charRecReg    <= 1'b0;
            frameErrReg   <= 1'b0;
        end else begin
            stateReg      <= stateNext;
            sampleCntReg  <= sampleCntNext;
            bitIDCountReg <= bitIDCountNext;
            shiftReg      <= shiftNext;
            rxDataReg     <= rxDataNext;
            charRecReg    <= charRecNext;
            frameErrReg   <= frameErrNext;
        end
    end

    always_comb begin
        stateNext      = stateReg;
        sampleCntNext  = sampleCntReg;
        bitIDCountNext = bitIDCountReg;
        shiftNext      = shiftReg;
        rxDataNext     = rxDataReg;
        charRecNext    = 1'b0;
        frameErrNext   = frameErrReg;

        // Disable wins over a coincident tick and drops any partial frame.
        if (!recvEn) begin
            stateNext      = IDLE;
            sampleCntNext  = '0;
            bitIDCountNext = '0;
            shiftNext      = '0;
        end else if (sampleTick) begin
            case (stateReg)
                IDLE: begin
                    if (!serS) begin
                        stateNext     = START;
                        sampleCntNext = '0;
                    end
                end
                START: begin
                    if (sampleCntReg == MID_CNT) begin
                        sampleCntNext = '0;
                        if (!serS) begin
                            stateNext      = DATA;
                            bitIDCountNext = '0;
                        end else begin
                            stateNext = IDLE;
                        end
                    end else begin
                        sampleCntNext = sampleCntReg + 1'b1;
                    end
                end
                DATA: begin
                    if (sampleCntReg == LAST_CNT) begin
                        shiftNext     = {serS, shiftReg[DATA_BITS-1:1]};
                        sampleCntNext = '0;
                        if (bitIDCountReg == LAST_BIT) begin
                            stateNext      = STOP;
                            bitIDCountNext = '0;
                        end else begin
                            bitIDCountNext = bitIDCountReg + 1'b1;
                        end
                    end else begin
                        sampleCntNext = sampleCntReg + 1'b1;
                    end
                end
                STOP: begin
                    if (sampleCntReg == LAST_CNT) begin
                        // Back to IDLE at mid-stop so a zero-gap next start is seen.
                        stateNext     = IDLE;
                        sampleCntNext = '0;
                        if (serS) begin
                            rxDataNext   = shiftReg;
                            charRecNext  = 1'b1;
                            frameErrNext = 1'b0;
                        end else begin
                            frameErrNext = 1'b1;
                        end
                    end else begin
                        sampleCntNext = sampleCntReg + 1'b1;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    assign rxData       = rxDataReg;
    assign charReceived = charRecReg;
    assign frameErr     = frameErrReg;
    assign busy         = (stateReg != IDLE);

endmodule

// File: tb/tb_bic_receive_ctrl.sv
// Self-checking bench for bic_receive_ctrl: serial frames in, scoreboard of expected bytes out.
module tb_bic_receive_ctrl;
    import bic_pkg::*;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       recvEn = 1'b0;
    logic       sampleTick = 1'b0;
    logic       serIn = 1'b1;
    logic [7:0] rxData;
    logic       charReceived;
    logic       frameErr;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int pulseCount = 0;
    int busyCnt = 0;
    int tickDiv = 0;
    logic [7:0] expQ[$];

    bic_receive_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .recvEn       (recvEn),
        .sampleTick   (sampleTick),
        .serIn        (serIn),
        .rxData       (rxData),
        .charReceived (charReceived),
        .frameErr     (frameErr),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // One sampleTick every 4 clocks.
    always @(negedge clk) begin
        tickDiv = (tickDiv + 1) % 4;
        sampleTick = (tickDiv == 0);
    end

    // Scoreboard: every pulse must match the oldest expected byte.
    always @(negedge clk) begin
        if (busy) busyCnt = busyCnt + 1;
        if (charReceived === 1'b1) begin
            pulseCount = pulseCount + 1;
            checks = checks + 1;
            if (expQ.size() == 0) begin
                failures = failures + 1;
                $display("FAIL unexpected_pulse rxData=%02h expected=none", rxData);
            end else begin
                logic [7:0] e;
                e = expQ.pop_front();
                if (rxData !== e) begin
                    failures = failures + 1;
                    $display("FAIL rx_byte got=%02h expected=%02h", rxData, e);
                end else begin
                    $display("rx byte %02h ok", rxData);
                end
            end
            checks = checks + 1;
            if (frameErr !== 1'b0) begin
                failures = failures + 1;
                $display("FAIL pulse_frameErr got=%b expected=0", frameErr);
            end
        end
    end

    task automatic waitTick();
        do @(posedge clk); while (sampleTick !== 1'b1);
        #1;
    endtask

    task automatic idleTicks(input int n);
        serIn = 1'b1;
        for (int i = 0; i < n; i++) waitTick();
    endtask

    // Drives frame bits LSB first (bit 0 = start), OS ticks per bit, for nTicks ticks.
    task automatic driveBits(input logic [FRAME_BITS-1:0] f, input int nTicks);
        waitTick();
        for (int i = 0; i < nTicks; i++) begin
            serIn = f[i / OS];
            waitTick();
        end
        serIn = 1'b1;
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stopBit);
        driveBits({stopBit, b, 1'b0}, FRAME_BITS * OS);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (rxData !== 8'h00 || charReceived !== 1'b0 || frameErr !== 1'b0 || busy !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL reset_state got rx=%02h cr=%b fe=%b busy=%b expected 00/0/0/0",
                     rxData, charReceived, frameErr, busy);
        end
        $display("reset state checked");
        rst = 1'b1;
        recvEn = 1'b1;
        idleTicks(4);
    endtask

    task automatic test_single_frame();
        int p0;
        p0 = pulseCount;
        busyCnt = 0;
        expQ.push_back(8'hA5);
        sendByte(8'hA5, 1'b1);
        idleTicks(4);
        checks = checks + 1;
        if (pulseCount - p0 !== 1) begin
            failures = failures + 1;
            $display("FAIL a5_pulses got=%0d expected=1", pulseCount - p0);
        end
        checks = checks + 1;
        if (busyCnt !== 152 * 4) begin
            failures = failures + 1;
            $display("FAIL a5_busy_clocks got=%0d expected=%0d", busyCnt, 152 * 4);
        end
        checks = checks + 1;
        if (rxData !== 8'hA5 || frameErr !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL a5_hold got rx=%02h fe=%b expected a5/0", rxData, frameErr);
        end
        $display("frame a5 done busyClocks=%0d", busyCnt);
    endtask

    task automatic test_glitch();
        int p0;
        p0 = pulseCount;
        driveBits(10'h3FE, 4);
        waitTick(); waitTick();
        checks = checks + 1;
        if (busy !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL glitch_detect busy=%b expected=1", busy);
        end
        idleTicks(8);
        checks = checks + 1;
        if (busy !== 1'b0 || pulseCount !== p0 || rxData !== 8'hA5) begin
            failures = failures + 1;
            $display("FAIL glitch_reject got busy=%b pulses=%0d rx=%02h expected 0/%0d/a5",
                     busy, pulseCount, rxData, p0);
        end
        $display("glitch rejected");
        idleTicks(4);
    endtask

    task automatic test_frame_error();
        int p0;
        p0 = pulseCount;
        sendByte(8'h3C, 1'b0);
        idleTicks(24);
        checks = checks + 1;
        if (frameErr !== 1'b1 || rxData !== 8'hA5 || pulseCount !== p0) begin
            failures = failures + 1;
            $display("FAIL bad_stop got fe=%b rx=%02h pulses=%0d expected 1/a5/%0d",
                     frameErr, rxData, pulseCount, p0);
        end
        $display("bad stop frame 3c flagged");
        expQ.push_back(8'h3C);
        sendByte(8'h3C, 1'b1);
        idleTicks(4);
        checks = checks + 1;
        if (frameErr !== 1'b0 || rxData !== 8'h3C || pulseCount !== p0 + 1) begin
            failures = failures + 1;
            $display("FAIL good_after_bad got fe=%b rx=%02h pulses=%0d expected 0/3c/%0d",
                     frameErr, rxData, pulseCount, p0 + 1);
        end
        $display("good frame 3c clears frameErr");
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = pulseCount;
        expQ.push_back(8'h00);
        expQ.push_back(8'hFF);
        sendByte(8'h00, 1'b1);
        sendByte(8'hFF, 1'b1);
        idleTicks(4);
        checks = checks + 1;
        if (pulseCount - p0 !== 2 || rxData !== 8'hFF || frameErr !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL back_to_back got pulses=%0d rx=%02h fe=%b expected 2/ff/0",
                     pulseCount - p0, rxData, frameErr);
        end
        $display("back-to-back 00,ff done");
    endtask

    task automatic test_reset_mid_frame();
        int p0;
        driveBits({1'b1, 8'h81, 1'b0}, 4 * OS + OS / 2);
        checks = checks + 1;
        if (busy !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL mid_frame_busy busy=%b expected=1", busy);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks = checks + 1;
        if (rxData !== 8'h00 || charReceived !== 1'b0 || frameErr !== 1'b0 || busy !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL mid_reset got rx=%02h cr=%b fe=%b busy=%b expected 00/0/0/0",
                     rxData, charReceived, frameErr, busy);
        end
        $display("reset mid-frame cleared outputs");
        idleTicks(20);
        p0 = pulseCount;
        expQ.push_back(8'h81);
        sendByte(8'h81, 1'b1);
        idleTicks(4);
        checks = checks + 1;
        if (pulseCount - p0 !== 1 || rxData !== 8'h81) begin
            failures = failures + 1;
            $display("FAIL after_reset got pulses=%0d rx=%02h expected 1/81", pulseCount - p0, rxData);
        end
    endtask

    task automatic test_recv_disable();
        int p0;
        p0 = pulseCount;
        driveBits({1'b1, 8'h55, 1'b0}, 4 * OS + OS / 2);
        recvEn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks = checks + 1;
        if (busy !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL disable_busy busy=%b expected=0", busy);
        end
        idleTicks(20);
        busyCnt = 0;
        sendByte(8'h55, 1'b1);
        idleTicks(4);
        checks = checks + 1;
        if (pulseCount !== p0 || busyCnt !== 0 || rxData !== 8'h81) begin
            failures = failures + 1;
            $display("FAIL disabled_ignore got pulses=%0d busyClocks=%0d rx=%02h expected %0d/0/81",
                     pulseCount, busyCnt, rxData, p0);
        end
        $display("recvEn low frames ignored");
        recvEn = 1'b1;
        idleTicks(4);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_recv_disable();
        checks = checks + 1;
        if (expQ.size() != 0) begin
            failures = failures + 1;
            $display("FAIL missing_pulses remaining=%0d expected=0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
